// File: rtl/cpu_bootloader.sv
// cpu_bootloader: loads a program image, one word per strobe from asynchronous
// board pins, into CPU program memory through the CPU bl_* port. The CPU is
// held in programming mode for the whole session.
// Optional feature macro: CPU_BOOTLOADER_CHECKSUM_EN. When it is defined, one
// extra word is accepted after the image and compared with the modular sum of
// the image words; error_o reports a mismatch.
module cpu_bootloader #(
  parameter int DATA_WIDTH           = 4,
  parameter int MEMORY_ADDRESS_WIDTH = 4,
  parameter int MEMORY_REGISTERS     = 16,
  parameter int SYNC_STAGES          = 2
) (
  input  logic                            clk_i,
  input  logic                            reset_i,
  input  logic                            programm_i,
  input  logic                            strobe_i,
  input  logic [DATA_WIDTH-1:0]           data_i,
  output logic                            bl_programm_o,
  output logic [DATA_WIDTH-1:0]           bl_data_o,
  output logic [MEMORY_ADDRESS_WIDTH-1:0] bl_address_o,
  output logic                            bl_write_en_mem_o,
  output logic                            ack_o,
  output logic                            done_o,
  output logic                            error_o
);

  localparam logic [MEMORY_ADDRESS_WIDTH-1:0] LAST_ADDR =
    MEMORY_ADDRESS_WIDTH'(MEMORY_REGISTERS - 1);
  localparam logic [MEMORY_ADDRESS_WIDTH-1:0] ADDR_ONE =
    MEMORY_ADDRESS_WIDTH'(1);

`ifdef CPU_BOOTLOADER_CHECKSUM_EN
  typedef enum logic [2:0] {IDLE, RECEIVE, WRITE, CHECK, DONE} state_t;
  logic [DATA_WIDTH-1:0] checksum;
  logic                  error_q;
  assign error_o = error_q;
`else
  typedef enum logic [2:0] {IDLE, RECEIVE, WRITE, DONE} state_t;
  assign error_o = 1'b0;
`endif

  state_t                  state;
  logic [SYNC_STAGES-1:0]  programm_sync;
  logic [SYNC_STAGES-1:0]  strobe_sync;
  logic                    strobe_prev;
  logic                    programm_s;
  logic                    strobe_edge;

  assign programm_s  = programm_sync[SYNC_STAGES-1];
  assign strobe_edge = strobe_sync[SYNC_STAGES-1] & ~strobe_prev;

  // Synchronise the asynchronous pins and keep the previous strobe level
  // for rising-edge detection.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      programm_sync <= '0;
      strobe_sync   <= '0;
      strobe_prev   <= 1'b0;
    end else begin
      programm_sync <= {programm_sync[SYNC_STAGES-2:0], programm_i};
      strobe_sync   <= {strobe_sync[SYNC_STAGES-2:0], strobe_i};
      strobe_prev   <= strobe_sync[SYNC_STAGES-1];
    end
  end

  // Loader FSM with registered outputs. A low programm level overrides every
  // state, so aborts and the normal DONE release share one path to IDLE; this
  // also drops a capture that coincides with the release.
  always_ff @(posedge clk_i or negedge reset_i) begin
    if (!reset_i) begin
      state             <= IDLE;
      bl_programm_o     <= 1'b0;
      bl_data_o         <= '0;
      bl_address_o      <= '0;
      bl_write_en_mem_o <= 1'b0;
      ack_o             <= 1'b0;
      done_o            <= 1'b0;
`ifdef CPU_BOOTLOADER_CHECKSUM_EN
      checksum          <= '0;
      error_q           <= 1'b0;
`endif
    end else begin
      bl_write_en_mem_o <= 1'b0;
      if (!programm_s) begin
        state         <= IDLE;
        bl_programm_o <= 1'b0;
        bl_data_o     <= '0;
        bl_address_o  <= '0;
        ack_o         <= 1'b0;
        done_o        <= 1'b0;
`ifdef CPU_BOOTLOADER_CHECKSUM_EN
        checksum      <= '0;
        error_q       <= 1'b0;
`endif
      end else begin
        case (state)
          IDLE: begin
            state         <= RECEIVE;
            bl_address_o  <= '0;
            bl_programm_o <= 1'b1;
          end
          RECEIVE: begin
            if (strobe_edge) begin
              bl_data_o         <= data_i;
              bl_write_en_mem_o <= 1'b1;
              ack_o             <= ~ack_o;
              state             <= WRITE;
`ifdef CPU_BOOTLOADER_CHECKSUM_EN
              checksum          <= checksum + data_i;
`endif
            end
          end
          WRITE: begin
            if (bl_address_o == LAST_ADDR) begin
`ifdef CPU_BOOTLOADER_CHECKSUM_EN
              state  <= CHECK;
`else
              state  <= DONE;
              done_o <= 1'b1;
`endif
            end else begin
              bl_address_o <= bl_address_o + ADDR_ONE;
              state        <= RECEIVE;
            end
          end
`ifdef CPU_BOOTLOADER_CHECKSUM_EN
          CHECK: begin
            if (strobe_edge) begin
              ack_o   <= ~ack_o;
              error_q <= (data_i != checksum);
              done_o  <= 1'b1;
              state   <= DONE;
            end
          end
`endif
          DONE: begin
            done_o <= 1'b1;
          end
          default: state <= IDLE;
        endcase
      end
    end
  end

endmodule

// File: tb/tb_cpu_bootloader.sv
// Directed bench for cpu_bootloader: a default-size instance and an 8-bit,
// 20-word instance share the pin stimulus.
module tb_cpu_bootloader;

  logic       clk = 1'b0;
  logic       reset_i = 1'b0;
  logic       programm = 1'b0;
  logic       strobe = 1'b0;
  logic [7:0] data = 8'h00;

  logic       n_prog, n_we, n_ack, n_done, n_err;
  logic [3:0] n_data, n_addr;
  logic       w_prog, w_we, w_ack, w_done, w_err;
  logic [7:0] w_data;
  logic [4:0] w_addr;

  int checks = 0;
  int failures = 0;

  int       n_wr = 0, n_acks = 0, n_dbl = 0;
  logic [3:0] n_addr_log [0:31];
  logic [3:0] n_data_log [0:31];
  logic     n_we_prev = 1'b0, n_ack_prev = 1'b0;
  int       w_wr = 0, w_acks = 0;
  logic [4:0] w_last_addr = '0;
  logic [7:0] w_last_data = '0;
  logic     w_ack_prev = 1'b0;

  always #5 clk = ~clk;

  cpu_bootloader u_narrow (
    .clk_i(clk), .reset_i(reset_i), .programm_i(programm), .strobe_i(strobe),
    .data_i(data[3:0]), .bl_programm_o(n_prog), .bl_data_o(n_data),
    .bl_address_o(n_addr), .bl_write_en_mem_o(n_we), .ack_o(n_ack),
    .done_o(n_done), .error_o(n_err)
  );

  cpu_bootloader #(
    .DATA_WIDTH(8), .MEMORY_ADDRESS_WIDTH(5), .MEMORY_REGISTERS(20), .SYNC_STAGES(2)
  ) u_wide (
    .clk_i(clk), .reset_i(reset_i), .programm_i(programm), .strobe_i(strobe),
    .data_i(data), .bl_programm_o(w_prog), .bl_data_o(w_data),
    .bl_address_o(w_addr), .bl_write_en_mem_o(w_we), .ack_o(w_ack),
    .done_o(w_done), .error_o(w_err)
  );

  // Observe writes and ack toggles mid-cycle.
  always @(negedge clk) begin
    if (n_we) begin
      if (n_wr < 32) begin
        n_addr_log[n_wr] = n_addr;
        n_data_log[n_wr] = n_data;
      end
      n_wr++;
      if (n_we_prev) n_dbl++;
    end
    n_we_prev = n_we;
    if (n_ack !== n_ack_prev) n_acks++;
    n_ack_prev = n_ack;
    if (w_we) begin
      w_wr++;
      w_last_addr = w_addr;
      w_last_data = w_data;
    end
    if (w_ack !== w_ack_prev) w_acks++;
    w_ack_prev = w_ack;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic zero_counts();
    n_wr = 0; n_acks = 0; w_wr = 0; w_acks = 0;
  endtask

  // mode 0: fixed timing, 1: wait for narrow ack, 2: wait for wide ack
  task automatic send_word(input logic [7:0] w, input int mode);
    logic n0, w0, got;
    n0 = n_ack; w0 = w_ack; got = 1'b0;
    data = w;
    @(negedge clk);
    strobe = 1'b1;
    if (mode != 0) begin
      for (int k = 0; k < 40; k++) begin
        @(negedge clk);
        if ((mode == 1 && n_ack !== n0) || (mode == 2 && w_ack !== w0)) begin
          got = 1'b1;
          break;
        end
      end
      check("ack_timeout", {31'd0, got}, 32'd1);
    end else begin
      repeat (8) @(negedge clk);
    end
    repeat (2) @(negedge clk);
    strobe = 1'b0;
    repeat (6) @(negedge clk);
  endtask

  task automatic check_narrow_zero(input string tag);
    check({tag, "_prog"}, {31'd0, n_prog}, 32'd0);
    check({tag, "_we"},   {31'd0, n_we},   32'd0);
    check({tag, "_ack"},  {31'd0, n_ack},  32'd0);
    check({tag, "_done"}, {31'd0, n_done}, 32'd0);
    check({tag, "_err"},  {31'd0, n_err},  32'd0);
    check({tag, "_data"}, {28'd0, n_data}, 32'd0);
    check({tag, "_addr"}, {28'd0, n_addr}, 32'd0);
  endtask

  initial begin
    logic saw_we;
    // Reset state
    repeat (3) @(negedge clk);
    check_narrow_zero("rst");
    check("rst_w_prog", {31'd0, w_prog}, 32'd0);
    reset_i = 1'b1;
    repeat (2) @(negedge clk);
    zero_counts();

    // Full image, programm latency
    programm = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("prog_lat_early", {31'd0, n_prog}, 32'd0);
    @(negedge clk);
    check("prog_lat", {31'd0, n_prog}, 32'd1);
    check("prog_lat_w", {31'd0, w_prog}, 32'd1);
    for (int i = 0; i < 20; i++) send_word(8'(i), 2);
    check("n_writes", n_wr, 32'd16);
    for (int i = 0; i < 16; i++) begin
      check("n_addr", {28'd0, n_addr_log[i]}, i);
      check("n_data", {28'd0, n_data_log[i]}, i);
    end
    check("n_done", {31'd0, n_done}, 32'd1);
    check("n_prog_held", {31'd0, n_prog}, 32'd1);
`ifdef CPU_BOOTLOADER_CHECKSUM_EN
    // word 16 carries low nibble 0; sum of 0..15 is 120 -> 8
    check("n_acks", n_acks, 32'd17);
    check("n_err", {31'd0, n_err}, 32'd1);
`else
    check("n_acks", n_acks, 32'd16);
    check("n_err", {31'd0, n_err}, 32'd0);
`endif
    check("w_writes", w_wr, 32'd20);
    check("w_last_addr", {27'd0, w_last_addr}, 32'd19);
    check("w_last_data", {24'd0, w_last_data}, 32'h13);
    check("w_acks", w_acks, 32'd20);
`ifdef CPU_BOOTLOADER_CHECKSUM_EN
    check("w_done_pre", {31'd0, w_done}, 32'd0);
    send_word(8'd190, 0);
    send_word(8'h55, 0);
    check("w_acks_post", w_acks, 32'd21);
    check("w_err", {31'd0, w_err}, 32'd0);
`else
    check("w_done_pre", {31'd0, w_done}, 32'd1);
    send_word(8'hAA, 0);
    send_word(8'h55, 0);
    check("w_acks_post", w_acks, 32'd20);
`endif
    check("w_writes_post", w_wr, 32'd20);
    check("w_done", {31'd0, w_done}, 32'd1);
    programm = 1'b0;
    repeat (5) @(negedge clk);
    check("rel_prog", {31'd0, n_prog}, 32'd0);
    check("rel_done", {31'd0, n_done}, 32'd0);

    // Abort after word 5, then restart
    zero_counts();
    programm = 1'b1;
    repeat (2) @(negedge clk);
    for (int i = 0; i < 5; i++) send_word(8'(i + 3), 1);
    programm = 1'b0;
    repeat (6) @(negedge clk);
    check("abort_writes", n_wr, 32'd5);
    for (int i = 0; i < 5; i++) begin
      check("abort_addr", {28'd0, n_addr_log[i]}, i);
      check("abort_data", {28'd0, n_data_log[i]}, i + 3);
    end
    check("abort_done", {31'd0, n_done}, 32'd0);
    check("abort_prog", {31'd0, n_prog}, 32'd0);
    programm = 1'b1;
    repeat (4) @(negedge clk);
    send_word(8'h09, 1);
    check("restart_writes", n_wr, 32'd6);
    check("restart_addr", {28'd0, n_addr_log[5]}, 32'd0);
    check("restart_data", {28'd0, n_data_log[5]}, 32'd9);
    programm = 1'b0;
    repeat (5) @(negedge clk);

`ifdef CPU_BOOTLOADER_CHECKSUM_EN
    // Checksum: sixteen 1s sum to 0 mod 16
    for (int s = 0; s < 2; s++) begin
      zero_counts();
      programm = 1'b1;
      repeat (3) @(negedge clk);
      for (int i = 0; i < 16; i++) send_word(8'h01, 1);
      send_word((s == 0) ? 8'h00 : 8'h05, 1);
      check("cs_writes", n_wr, 32'd16);
      check("cs_done", {31'd0, n_done}, 32'd1);
      check("cs_err", {31'd0, n_err}, (s == 0) ? 32'd0 : 32'd1);
      programm = 1'b0;
      repeat (5) @(negedge clk);
      check("cs_rel_err", {31'd0, n_err}, 32'd0);
    end
`endif

    // Reset during a write pulse
    programm = 1'b1;
    repeat (4) @(negedge clk);
    data = 8'h03;
    strobe = 1'b1;
    saw_we = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (n_we) begin
        saw_we = 1'b1;
        break;
      end
    end
    check("rstw_saw_we", {31'd0, saw_we}, 32'd1);
    reset_i = 1'b0;
    #1;
    check_narrow_zero("rstw");
    strobe = 1'b0;
    programm = 1'b0;
    @(negedge clk);
    reset_i = 1'b1;
    repeat (2) @(negedge clk);
    zero_counts();
    repeat (4) @(negedge clk);
    check("post_rst_prog", {31'd0, n_prog}, 32'd0);
    send_word(8'h07, 0);
    check("post_rst_writes", n_wr, 32'd0);
    check("post_rst_done", {31'd0, n_done}, 32'd0);
    check("single_cycle_we", n_dbl, 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/cpu_bootloader.md
# cpu_bootloader

Parametrised program loader for the four-bit CPU family: receives a program image word-by-word over slow, asynchronous board pins and writes it into CPU program memory through the CPU's `bl_*` bootloader port, holding the CPU in programming mode while loading. It sits in the top level between the dedicated input pins and the `cpu` instance. It replaces the tied-off bootloader inputs of the first-generation top level and generalises them to any data width and memory depth.

## Interface
- `DATA_WIDTH`, 4: width of one memory word and of the pin data bus.
- `MEMORY_ADDRESS_WIDTH`, 4: width of the memory address.
- `MEMORY_REGISTERS`, 16: number of words loaded per image; legal range 1 to 2^MEMORY_ADDRESS_WIDTH.
- `SYNC_STAGES`, 2: flip-flop stages on each asynchronous pin input; minimum 2.

- `clk_i` in 1: system clock.
- `reset_i` in 1: asynchronous, active-low reset.
- `programm_i` in 1: async pin; high requests programming mode, low releases it.
- `strobe_i` in 1: async pin; each rising edge presents one word on `data_i`.
- `data_i` in DATA_WIDTH: async pins; word value, stable from before `strobe_i` rises until `ack_o` toggles.
- `bl_programm_o` out 1: holds the CPU in programming mode.
- `bl_data_o` out DATA_WIDTH: word to write.
- `bl_address_o` out MEMORY_ADDRESS_WIDTH: write address.
- `bl_write_en_mem_o` out 1: one-cycle memory write pulse.
- `ack_o` out 1: toggles once per accepted word.
- `done_o` out 1: image complete.
- `error_o` out 1: checksum mismatch (see Configuration).

## Operation
- `programm_i` and `strobe_i` pass through SYNC_STAGES synchronisers. A rising edge of `strobe_i` is detected on the synchronised signal using one extra register. `data_i` is sampled on the detected edge.
- FSM states: IDLE, RECEIVE, WRITE, CHECK (only with the macro), DONE.
- IDLE: all outputs low. Synchronised `programm_i` high -> RECEIVE; address counter cleared to 0; `bl_programm_o` goes 1.
- RECEIVE: on a strobe edge, capture `data_i` into the data register and go to WRITE.
- WRITE: assert `bl_write_en_mem_o` for exactly one cycle with the current address and data, and toggle `ack_o`. Then:
  - if address = MEMORY_REGISTERS-1: go to DONE, or to CHECK with the macro;
  - otherwise: increment the address and return to RECEIVE.
- DONE: `done_o`=1 and `bl_programm_o` stays 1. Synchronised `programm_i` low -> IDLE, with `bl_programm_o`, `done_o` and `error_o` cleared.
- Abort: synchronised `programm_i` low in RECEIVE, WRITE or CHECK -> IDLE next cycle. A pending WRITE pulse is suppressed in that case. The address is not advanced, and `done_o` stays 0.
- Address never wraps. Words strobed in DONE are ignored: no write and no `ack_o` toggle.
- Arithmetic: address increment is unsigned MEMORY_ADDRESS_WIDTH. Checksum is the sum of all words modulo 2^DATA_WIDTH.

## Timing
- Reset (asynchronous assert, synchronous-safe release): all outputs 0, FSM in IDLE, address 0, data 0, checksum 0, synchronisers 0.
- `strobe_i` rising at the pin -> edge detected SYNC_STAGES+1 cycles later; default 3.
- `bl_write_en_mem_o` pulse: the cycle after the edge is detected. `ack_o` toggles in the same cycle. `bl_address_o` and `bl_data_o` are valid in the pulse cycle and held until the next capture.
- The address increments on the clock edge ending the pulse.
- Host rule: `strobe_i` high and low each at least SYNC_STAGES+2 cycles. The next strobe may only rise after `ack_o` has toggled.
- `programm_i` high -> `bl_programm_o` high SYNC_STAGES+1 cycles later. Release follows the same latency.

## Configuration
- `CPU_BOOTLOADER_CHECKSUM_EN` defined: after the last image word, FSM enters CHECK and accepts one extra strobed word.
  - No memory write for this word.
  - `ack_o` toggles.
  - Word equal to the running checksum -> DONE with `error_o`=0.
  - Otherwise -> DONE with `error_o`=1.
- Undefined: no CHECK state, no checksum logic, `error_o` tied 0. DONE follows the last write directly.

## Test plan
- Defaults: load words 0x0..0xF -> sixteen `bl_write_en_mem_o` pulses at addresses 0..15 with data equal to address; `ack_o` toggles 16 times; `done_o`=1; `bl_programm_o` held until `programm_i` falls.
- Strobe 3 cycles after `programm_i` rises, then drop `programm_i` after word 5 -> writes at addresses 0..4 only; IDLE; `done_o`=0; new session restarts at address 0.
- With checksum: image of sixteen 0x1 words followed by checksum word 0x0 -> `error_o`=0. The same image followed by 0x5 -> `error_o`=1. No write occurs for the checksum word.
- `DATA_WIDTH`=8, `MEMORY_ADDRESS_WIDTH`=5, `MEMORY_REGISTERS`=20 -> exactly 20 writes, last at address 19; extra strobes in DONE produce no write and no `ack_o` toggle.
- Assert `reset_i` low during a WRITE pulse -> all outputs 0 immediately; after release, the FSM is in IDLE.
